// File: rtl/exc_sequencer.sv
// Commit-stage exception / ERET sequencer. It prioritises the exception sources and pulses the CP0 exception write port once.
// It then flushes the pipeline and redirects fetch to the exception vector or to EPC.
module exc_sequencer #(
  parameter logic [31:0] EXC_VECTOR   = 32'hBFC0_0380,
  parameter int          FLUSH_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        commit_valid,
  input  logic [31:0] commit_pc,
  input  logic        commit_bd,
  input  logic        exc_if_adel,
  input  logic        exc_ri,
  input  logic        exc_ov,
  input  logic        exc_sys,
  input  logic        exc_bp,
  input  logic        exc_mem_adel,
  input  logic        exc_mem_ades,
  input  logic [31:0] mem_badvaddr,
  input  logic        commit_eret,
  input  logic        allow_interrupt,
  input  logic [7:0]  interrupt_flag,
  input  logic [31:0] epc_address,
  output logic        exp_en,
  output logic        exp_badvaddr_en,
  output logic [31:0] exp_badvaddr,
  output logic        exp_bd,
  output logic [4:0]  exp_code,
  output logic [31:0] exp_epc,
  output logic        exl_clean,
  output logic        commit_kill,
  output logic        commit_stall,
  output logic        flush,
  output logic        redirect_valid,
  output logic [31:0] redirect_pc,
  input  logic        redirect_ready,
  output logic [1:0]  dbg_state
);

  typedef enum logic [1:0] {
    S_IDLE     = 2'd0,
    S_FLUSH    = 2'd1,
    S_REDIRECT = 2'd2
  } state_t;

  localparam int            CW         = $clog2(FLUSH_CYCLES + 1);
  localparam logic [CW-1:0] FLUSH_LOAD = CW'(FLUSH_CYCLES);

  state_t        state, state_nxt;
  logic [CW-1:0] flush_cnt;

  logic          irq;
  logic          exc_hit;
  logic [4:0]    exc_code_w;
  logic          badv_en_w;
  logic [31:0]   badv_w;
  logic          trigger;
  logic          take_eret;

  logic [4:0]    last_code;
  logic          last_bd;
  logic [31:0]   target_q;

  assign irq = allow_interrupt & (|interrupt_flag);

  // Fixed-priority encoder; the interrupt outranks every synchronous exception.
  always_comb begin
    exc_hit    = 1'b1;
    exc_code_w = 5'd0;
    badv_en_w  = 1'b0;
    badv_w     = 32'd0;
    if (irq) begin
      exc_code_w = 5'd0;
    end else if (exc_if_adel) begin
      exc_code_w = 5'd4;
      badv_en_w  = 1'b1;
      badv_w     = commit_pc;
    end else if (exc_ri) begin
      exc_code_w = 5'd10;
    end else if (exc_ov) begin
      exc_code_w = 5'd12;
    end else if (exc_sys) begin
      exc_code_w = 5'd8;
    end else if (exc_bp) begin
      exc_code_w = 5'd9;
    end else if (exc_mem_adel) begin
      exc_code_w = 5'd4;
      badv_en_w  = 1'b1;
      badv_w     = mem_badvaddr;
    end else if (exc_mem_ades) begin
      exc_code_w = 5'd5;
      badv_en_w  = 1'b1;
      badv_w     = mem_badvaddr;
    end else begin
      exc_hit = 1'b0;
    end
  end

  assign trigger   = ~rst & commit_valid & (state == S_IDLE) & (exc_hit | commit_eret);
  assign take_eret = trigger & ~exc_hit;

  // State register and flush down-counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      flush_cnt <= '0;
    end else begin
      state <= state_nxt;
      if (trigger)
        flush_cnt <= FLUSH_LOAD;
      else if (state == S_FLUSH && flush_cnt != '0)
        flush_cnt <= flush_cnt - 1'b1;
    end
  end

  // Redirect handshake: redirect_valid rises in REDIRECT and stays high with a
  // stable redirect_pc until the first cycle redirect_ready is seen high;
  // redirect_ready is ignored whenever redirect_valid is low.
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:     if (trigger) state_nxt = S_FLUSH;
      S_FLUSH:    if (flush_cnt == {{(CW-1){1'b0}}, 1'b1}) state_nxt = S_REDIRECT;
      S_REDIRECT: if (redirect_ready) state_nxt = S_IDLE;
      default:    state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    commit_kill    = trigger & ~take_eret;
    commit_stall   = (state != S_IDLE);
    flush          = (state == S_FLUSH);
    redirect_valid = (state == S_REDIRECT);
    redirect_pc    = target_q;
    dbg_state      = state;
  end

  // Capture the CP0 write payload at trigger; exp_en is a one-cycle pulse.
  always_ff @(posedge clk) begin
    if (rst) begin
      exp_en          <= 1'b0;
      exp_badvaddr_en <= 1'b0;
      exp_badvaddr    <= 32'd0;
      exp_bd          <= 1'b0;
      exp_code        <= 5'd0;
      exp_epc         <= 32'd0;
      exl_clean       <= 1'b0;
      target_q        <= 32'd0;
      last_code       <= 5'd0;
      last_bd         <= 1'b0;
    end else begin
      exp_en <= trigger;
      if (trigger) begin
        if (take_eret) begin
          exp_code        <= last_code;
          exp_bd          <= last_bd;
          exp_epc         <= epc_address;
          exp_badvaddr_en <= 1'b0;
          exl_clean       <= 1'b1;
          target_q        <= epc_address;
        end else begin
          exp_code        <= exc_code_w;
          exp_bd          <= commit_bd;
          exp_epc         <= commit_bd ? (commit_pc - 32'd4) : commit_pc;
          exp_badvaddr_en <= badv_en_w;
          exp_badvaddr    <= badv_w;
          exl_clean       <= 1'b0;
          target_q        <= EXC_VECTOR;
          last_code       <= exc_code_w;
          last_bd         <= commit_bd;
        end
      end
    end
  end

endmodule

// File: tb/tb_exc_sequencer.sv
// Directed bench for exc_sequencer: hand-computed expectations per cycle,
// redirect targets tracked through an expected queue.
module tb_exc_sequencer;

  localparam logic [31:0] VEC = 32'hBFC0_0380;

  logic        clk = 1'b0;
  logic        rst;
  logic        commit_valid, commit_bd, commit_eret;
  logic [31:0] commit_pc, mem_badvaddr, epc_address;
  logic        exc_if_adel, exc_ri, exc_ov, exc_sys, exc_bp, exc_mem_adel, exc_mem_ades;
  logic        allow_interrupt;
  logic [7:0]  interrupt_flag;
  logic        redirect_ready;
  logic        exp_en, exp_badvaddr_en, exp_bd, exl_clean;
  logic [31:0] exp_badvaddr, exp_epc, redirect_pc;
  logic [4:0]  exp_code;
  logic        commit_kill, commit_stall, flush, redirect_valid;
  logic [1:0]  dbg_state;

  logic [31:0] exp_q[$];
  int n_cmp = 0;
  int n_err = 0;

  exc_sequencer dut (
    .clk(clk), .rst(rst),
    .commit_valid(commit_valid), .commit_pc(commit_pc), .commit_bd(commit_bd),
    .exc_if_adel(exc_if_adel), .exc_ri(exc_ri), .exc_ov(exc_ov), .exc_sys(exc_sys),
    .exc_bp(exc_bp), .exc_mem_adel(exc_mem_adel), .exc_mem_ades(exc_mem_ades),
    .mem_badvaddr(mem_badvaddr), .commit_eret(commit_eret),
    .allow_interrupt(allow_interrupt), .interrupt_flag(interrupt_flag),
    .epc_address(epc_address),
    .exp_en(exp_en), .exp_badvaddr_en(exp_badvaddr_en), .exp_badvaddr(exp_badvaddr),
    .exp_bd(exp_bd), .exp_code(exp_code), .exp_epc(exp_epc), .exl_clean(exl_clean),
    .commit_kill(commit_kill), .commit_stall(commit_stall), .flush(flush),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .redirect_ready(redirect_ready), .dbg_state(dbg_state)
  );

  // Clock / reset
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_cmp++;
    if (got !== want) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, want);
    end
  endtask

  // Driver tasks
  task automatic clear_inputs();
    commit_valid = 0; commit_bd = 0; commit_eret = 0; commit_pc = 0;
    exc_if_adel = 0; exc_ri = 0; exc_ov = 0; exc_sys = 0; exc_bp = 0;
    exc_mem_adel = 0; exc_mem_ades = 0; mem_badvaddr = 0;
    allow_interrupt = 0; interrupt_flag = 0;
  endtask

  task automatic finish_seq(input string tag);
    int n = 0;
    logic [31:0] want;
    while (!redirect_valid && n < 20) begin
      tick();
      n++;
    end
    check({tag, "_rv_seen"}, redirect_valid, 1);
    want = (exp_q.size() > 0) ? exp_q.pop_front() : 32'hDEAD_BEEF;
    check({tag, "_redirect_pc"}, redirect_pc, want);
    redirect_ready = 1;
    tick();
    redirect_ready = 0;
    check({tag, "_idle"}, commit_stall, 0);
  endtask

  initial begin
    clear_inputs();
    epc_address = 0;
    redirect_ready = 0;
    rst = 1;
    repeat (3) tick();
    check("rst_exp_en", exp_en, 0);
    check("rst_stall", commit_stall, 0);
    check("rst_flush", flush, 0);
    check("rst_rv", redirect_valid, 0);
    check("rst_exl_clean", exl_clean, 0);
    rst = 0;
    tick();

    // interrupts pending but not allowed: no trigger
    commit_valid = 1; interrupt_flag = 8'hFF; allow_interrupt = 0;
    #1 check("noirq_kill", commit_kill, 0);
    tick();
    clear_inputs();
    check("noirq_stall", commit_stall, 0);
    check("noirq_exp_en", exp_en, 0);

    // Test 1: overflow, exact cycle timing with late redirect_ready
    commit_valid = 1; commit_pc = 32'h8000_0100; exc_ov = 1;
    #1;
    check("t1_kill", commit_kill, 1);
    check("t1_stall_T", commit_stall, 0);
    exp_q.push_back(VEC);
    tick(); clear_inputs();                                  // T+1
    check("t1_exp_en", exp_en, 1);
    check("t1_code", exp_code, 12);
    check("t1_epc", exp_epc, 32'h8000_0100);
    check("t1_badv_en", exp_badvaddr_en, 0);
    check("t1_exl_clean", exl_clean, 0);
    check("t1_flush1", flush, 1);
    check("t1_stall1", commit_stall, 1);
    check("t1_rv1", redirect_valid, 0);
    tick();                                                  // T+2
    commit_valid = 1; exc_sys = 1;
    #1;
    check("t1_ignored_kill", commit_kill, 0);
    check("t1_exp_en_pulse", exp_en, 0);
    check("t1_flush2", flush, 1);
    tick(); clear_inputs();                                  // T+3
    check("t1_flush3", flush, 0);
    check("t1_rv3", redirect_valid, 1);
    check("t1_redirect_pc", redirect_pc, exp_q.pop_front());
    tick();                                                  // T+4
    check("t1_rv4", redirect_valid, 1);
    tick();                                                  // T+5
    redirect_ready = 1;
    check("t1_rv5", redirect_valid, 1);
    check("t1_stall5", commit_stall, 1);
    check("t1_pc5", redirect_pc, VEC);
    tick();                                                  // T+6
    redirect_ready = 0;
    check("t1_stall6", commit_stall, 0);
    check("t1_rv6", redirect_valid, 0);
    check("t1_state6", dbg_state, 0);

    // Test 2: store address error in delay slot, EPC wraps
    commit_valid = 1; commit_bd = 1; commit_pc = 32'h0; exc_mem_ades = 1;
    mem_badvaddr = 32'h1234_5671;
    exp_q.push_back(VEC);
    tick(); clear_inputs();
    check("t2_code", exp_code, 5);
    check("t2_epc", exp_epc, 32'hFFFF_FFFC);
    check("t2_bd", exp_bd, 1);
    check("t2_badv_en", exp_badvaddr_en, 1);
    check("t2_badv", exp_badvaddr, 32'h1234_5671);
    finish_seq("t2");

    // Test 3: everything at once -> interrupt wins, ERET killed
    commit_valid = 1; commit_pc = 32'h8000_0400; commit_eret = 1;
    {exc_if_adel, exc_ri, exc_ov, exc_sys, exc_bp, exc_mem_adel, exc_mem_ades} = 7'h7F;
    allow_interrupt = 1; interrupt_flag = 8'h04;
    #1 check("t3_kill", commit_kill, 1);
    exp_q.push_back(VEC);
    tick(); clear_inputs();
    check("t3_code", exp_code, 0);
    check("t3_epc", exp_epc, 32'h8000_0400);
    check("t3_exl_clean", exl_clean, 0);
    finish_seq("t3");

    // Test 4: RI in delay slot, then ERET rewrites Cause unchanged
    commit_valid = 1; commit_bd = 1; commit_pc = 32'h8000_0204; exc_ri = 1;
    exp_q.push_back(VEC);
    tick(); clear_inputs();
    check("t4a_code", exp_code, 10);
    check("t4a_epc", exp_epc, 32'h8000_0200);
    finish_seq("t4a");
    commit_valid = 1; commit_eret = 1; commit_pc = 32'h8000_0300;
    epc_address = 32'h8000_2000;
    #1 check("t4_eret_kill", commit_kill, 0);
    exp_q.push_back(32'h8000_2000);
    tick(); clear_inputs();
    epc_address = 32'h1111_1111;
    check("t4_exp_en", exp_en, 1);
    check("t4_exl_clean", exl_clean, 1);
    check("t4_code", exp_code, 10);
    check("t4_bd", exp_bd, 1);
    check("t4_epc", exp_epc, 32'h8000_2000);
    check("t4_badv_en", exp_badvaddr_en, 0);
    finish_seq("t4");

    // Test 5: fetch address error outranks load address error
    commit_valid = 1; commit_pc = 32'h8000_0003; exc_if_adel = 1;
    exc_mem_adel = 1; mem_badvaddr = 32'h5555_0000;
    exp_q.push_back(VEC);
    tick(); clear_inputs();
    check("t5_code", exp_code, 4);
    check("t5_badv_en", exp_badvaddr_en, 1);
    check("t5_badv", exp_badvaddr, 32'h8000_0003);
    finish_seq("t5");

    // Test 6: reset mid-REDIRECT clears state and last Cause
    commit_valid = 1; commit_bd = 1; commit_pc = 32'h8000_0010; exc_bp = 1;
    tick(); clear_inputs();
    check("t6_code", exp_code, 9);
    tick();
    tick();
    check("t6_rv", redirect_valid, 1);
    tick();
    rst = 1;
    tick();
    rst = 0;
    check("t6_rst_rv", redirect_valid, 0);
    check("t6_rst_stall", commit_stall, 0);
    check("t6_rst_flush", flush, 0);
    commit_valid = 1; commit_eret = 1; epc_address = 32'h8000_3000;
    exp_q.push_back(32'h8000_3000);
    tick(); clear_inputs();
    check("t6_eret_code", exp_code, 0);
    check("t6_eret_bd", exp_bd, 0);
    check("t6_eret_exl", exl_clean, 1);
    finish_seq("t6");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
